// File: rtl/uart_dump_pkg.sv
// uart_dump_pkg
// Shared types and constants for the UART memory dumper.
//   state_t          : dump controller FSM state encoding
//   CMD_DUMP_DEFAULT : default command byte that starts a dump
//   MEM_LATENCY      : read latency of the dumped memory, in cycles
// Optional feature macro: UART_DUMP_CHECKSUM_EN adds the CSUM state.
package uart_dump_pkg;

  localparam logic [7:0] CMD_DUMP_DEFAULT = 8'h64;
  localparam int         MEM_LATENCY      = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
`ifdef UART_DUMP_CHECKSUM_EN
    ST_CSUM  = 3'd4,
`endif
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/uart_dump_ctrl.sv
// uart_dump_ctrl
// Pops command bytes from the UART rx FIFO. When the dump command arrives,
// every byte of a synchronous-read memory from address 0 to DEPTH-1 is
// pushed into the UART tx FIFO, with tx_full back-pressure respected.
// Optional feature macro: UART_DUMP_CHECKSUM_EN appends one byte holding the
// modulo-256 sum of all dumped bytes.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   rx_empty   in   rx FIFO empty
//   r_data     in   rx FIFO head byte
//   rd_uart    out  rx FIFO pop pulse
//   tx_full    in   tx FIFO full
//   wr_uart    out  tx FIFO push pulse
//   w_data     out  byte to transmit (registered)
//   mem_addr   out  memory read address (registered)
//   mem_data   in   memory read data, one cycle after mem_addr
//   busy       out  dump in progress
//   done_tick  out  one-cycle pulse when a dump finishes
import uart_dump_pkg::*;

module uart_dump_ctrl #(
  parameter int         ADDR_W   = 13,
  parameter int         DEPTH    = 8192,
  parameter logic [7:0] CMD_DUMP = CMD_DUMP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              done_tick
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_wdata;
`ifdef UART_DUMP_CHECKSUM_EN
  logic [7:0]          r_sum;
`endif
  logic                w_rd;
  logic                w_wr;
  logic                w_done;
  logic                w_cmd_hit;
  logic                w_last;

  // A command is recognised only on the cycle it is actually popped.
  assign w_cmd_hit = ~rx_empty && (r_data == CMD_DUMP);
  // The address counter stops at DEPTH-1, so it can never wrap.
  assign w_last    = (r_addr == LAST_ADDR);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and handshake strobes.
  always_comb begin
    w_state_next = r_state;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_rd = ~rx_empty;
        if (w_cmd_hit) begin
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_FETCH: begin
        w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_state_next = ST_SEND;
      end
      ST_SEND: begin
        w_wr = ~tx_full;
        if (tx_full) begin
          w_state_next = ST_SEND;
        end else if (w_last) begin
`ifdef UART_DUMP_CHECKSUM_EN
          w_state_next = ST_CSUM;
`else
          w_state_next = ST_DONE;
`endif
        end else begin
          w_state_next = ST_FETCH;
        end
      end
`ifdef UART_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        w_wr = ~tx_full;
        if (tx_full) begin
          w_state_next = ST_CSUM;
        end else begin
          w_state_next = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Address counter, transmit byte register and checksum accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= 8'h00;
`ifdef UART_DUMP_CHECKSUM_EN
      r_sum   <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_hit) begin
            r_addr <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
            r_sum  <= 8'h00;
`endif
          end
        end
        ST_LOAD: begin
          // Memory data is valid here because FETCH presented the address.
          r_wdata <= mem_data;
        end
        ST_SEND: begin
          if (!tx_full) begin
`ifdef UART_DUMP_CHECKSUM_EN
            r_sum <= r_sum + r_wdata;
            // Preload the final sum so CSUM sends a stable registered byte.
            if (w_last) begin
              r_wdata <= r_sum + r_wdata;
            end
`endif
            if (!w_last) begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign w_data    = r_wdata;
  assign rd_uart   = w_rd;
  assign wr_uart   = w_wr;
  assign done_tick = w_done;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_dump_ctrl.sv
// tb_uart_dump_ctrl
// Scoreboard bench: stimulus pushes expected tx bytes (data, address, cycle
// spacing) into a queue; a negedge monitor pops and compares on each write.
// A small instance (ADDR_W=2, DEPTH=4) covers the directed cases; a default
// instance (ADDR_W=13, DEPTH=8192) covers the full-depth dump.
module tb_uart_dump_ctrl;

  typedef struct {
    logic [7:0] data;
    int         addr;
    int         delta;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- small instance ----------------
  logic        rx_empty, rd_uart, tx_full, wr_uart, busy, done_tick;
  logic [7:0]  r_data, w_data, mem_data;
  logic [1:0]  mem_addr;
  logic [7:0]  rx_mem [16];
  logic [3:0]  rx_wp = 4'd0;
  logic [3:0]  rx_rp = 4'd0;
  logic [7:0]  mem [4];

  assign rx_empty = (rx_wp == rx_rp);
  assign r_data   = rx_mem[rx_rp];

  always @(posedge clk) if (rd_uart) rx_rp <= rx_rp + 4'd1;
  always @(posedge clk) mem_data <= mem[mem_addr];

  uart_dump_ctrl #(.ADDR_W(2), .DEPTH(4), .CMD_DUMP(8'h64)) u_dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done_tick(done_tick)
  );

  // ---------------- full-depth instance ----------------
  logic        rx_empty_f, rd_uart_f, wr_uart_f, busy_f, done_tick_f;
  logic        tx_full_f = 1'b0;
  logic [7:0]  w_data_f, mem_data_f;
  logic [7:0]  r_data_f = 8'h64;
  logic [12:0] mem_addr_f;
  int          rxf_wp = 0;
  int          rxf_rp = 0;

  function automatic logic [7:0] fmem(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]};
  endfunction

  assign rx_empty_f = (rxf_wp == rxf_rp);
  always @(posedge clk) if (rd_uart_f) rxf_rp <= rxf_rp + 1;
  always @(posedge clk) mem_data_f <= fmem(mem_addr_f);

  uart_dump_ctrl u_full (
    .clk(clk), .reset(reset), .rx_empty(rx_empty_f), .r_data(r_data_f),
    .rd_uart(rd_uart_f), .tx_full(tx_full_f), .wr_uart(wr_uart_f), .w_data(w_data_f),
    .mem_addr(mem_addr_f), .mem_data(mem_data_f), .busy(busy_f), .done_tick(done_tick_f)
  );

  // ---------------- scoreboard state ----------------
  exp_t exp_q[$];
  int   wr_cnt = 0, pop_cnt = 0, done_cnt = 0, busy_cycles = 0;
  int   last_evt = 0, last_done_cyc = 0, last_pop_gap = 0;
  int   fw_cnt = 0, fdone = 0, f_last_addr = -1;
  logic [7:0] f_sum_exp = 8'h00;

  // Monitor for the small instance.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      if (busy) begin
        busy_cycles++;
        total++;
        if (rd_uart) begin bad++; $display("FAIL rd_while_busy: rd_uart=1 at cycle %0d, required 0", cyc); end
      end
      if (rd_uart) begin
        pop_cnt++;
        if (r_data == 8'h64) begin
          last_pop_gap = cyc - last_done_cyc;
          last_evt = cyc;
        end
      end
      if (wr_uart) begin
        wr_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got %h, required no write", w_data);
        end else begin
          e = exp_q.pop_front();
          if (w_data !== e.data) begin bad++; $display("FAIL wr_data: got %h required %h", w_data, e.data); end
          total++;
          if (int'(mem_addr) != e.addr) begin bad++; $display("FAIL wr_addr: got %0d required %0d", mem_addr, e.addr); end
          total++;
          if (cyc - last_evt != e.delta) begin bad++; $display("FAIL wr_spacing: got %0d required %0d", cyc - last_evt, e.delta); end
        end
        last_evt = cyc;
      end
      if (done_tick) begin done_cnt++; last_done_cyc = cyc; end
    end
  end

  // Monitor for the full-depth instance.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (busy_f && rd_uart_f) begin total++; bad++; $display("FAIL full_rd_while_busy at cycle %0d", cyc); end
      if (wr_uart_f) begin
        fw_cnt++;
        total++;
        if (fw_cnt <= 8192) begin
          if (w_data_f !== fmem(mem_addr_f)) begin bad++; $display("FAIL full_data: got %h required %h", w_data_f, fmem(mem_addr_f)); end
          total++;
          if (int'(mem_addr_f) != fw_cnt - 1) begin bad++; $display("FAIL full_addr: got %0d required %0d", mem_addr_f, fw_cnt - 1); end
          f_last_addr = int'(mem_addr_f);
        end else begin
          if (w_data_f !== f_sum_exp) begin bad++; $display("FAIL full_csum: got %h required %h", w_data_f, f_sum_exp); end
        end
      end
      if (done_tick_f) fdone++;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin bad++; $display("FAIL %s: got %0d required %0d", name, act, req); end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wp] = b;
    rx_wp = rx_wp + 4'd1;
  endtask

  task automatic expect_dump(input int stall);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.data = mem[i]; e.addr = i; e.delta = (i == 1) ? 3 + stall : 3;
      exp_q.push_back(e);
    end
`ifdef UART_DUMP_CHECKSUM_EN
    e.data = 8'h50; e.addr = 3; e.delta = 1;
    exp_q.push_back(e);
`endif
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done"}, done_cnt, target);
    check({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_write(input string name);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!wr_uart && n < 100);
    if (!wr_uart) begin total++; bad++; $display("FAIL %s: no write within 100 cycles", name); end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rd_uart"}, int'(rd_uart), 0);
    check({name, "_wr_uart"}, int'(wr_uart), 0);
    check({name, "_w_data"}, int'(w_data), 0);
    check({name, "_mem_addr"}, int'(mem_addr), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_done_tick"}, int'(done_tick), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int wr_before;
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'hF0;
    reset = 1'b1;
    tx_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_full_busy", int'(busy_f), 0);
    check("reset_full_addr", int'(mem_addr_f), 0);
    reset = 1'b0;

    // Idle rejection of a non-command byte.
    push_rx(8'h41);
    repeat (5) @(posedge clk);
    #1;
    check("idle_pops", pop_cnt, 1);
    check("idle_busy_cycles", busy_cycles, 0);
    check("idle_writes", wr_cnt, 0);
    check("idle_mem_addr", int'(mem_addr), 0);
    check("idle_rx_drained", int'(rx_empty), 1);

    // Basic dump.
    expect_dump(0);
    push_rx(8'h64);
    wait_done("basic", 1, 100);

    // Back-pressure: tx_full held for 10 cycles over the second SEND.
    expect_dump(10);
    push_rx(8'h64);
    wait_write("bp_first_write");
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    tx_full = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    tx_full = 1'b0;
    wait_done("backpressure", 2, 100);

    // Two queued commands.
    expect_dump(0);
    expect_dump(0);
    push_rx(8'h64);
    push_rx(8'h64);
    wait_done("queued", 4, 200);
    check("queued_pop_after_done", last_pop_gap, 1);

    // Reset after two writes of a dump.
    begin
      exp_t e;
      e.data = 8'h10; e.addr = 0; e.delta = 3; exp_q.push_back(e);
      e.data = 8'h20; e.addr = 1; e.delta = 3; exp_q.push_back(e);
    end
    wr_before = wr_cnt;
    push_rx(8'h64);
    wait_write("rst_write1");
    wait_write("rst_write2");
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midreset_writes", wr_cnt - wr_before, 2);
    check("midreset_no_done", done_cnt, 4);
    check("midreset_queue_left", exp_q.size(), 0);
    expect_dump(0);
    push_rx(8'h64);
    wait_done("after_reset", 5, 100);

    // Full-depth dump on the default-parameter instance.
    f_sum_exp = 8'h00;
    for (int i = 0; i < 8192; i++) f_sum_exp = f_sum_exp + fmem(13'(i));
    rxf_wp = rxf_wp + 1;
    n = 0;
    while (fdone < 1 && n < 30000) begin @(posedge clk); #1; n++; end
    repeat (5) @(posedge clk);
    #1;
`ifdef UART_DUMP_CHECKSUM_EN
    check("full_writes", fw_cnt, 8193);
`else
    check("full_writes", fw_cnt, 8192);
`endif
    check("full_last_addr", f_last_addr, 8191);
    check("full_done", fdone, 1);
    check("full_idle", int'(busy_f), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
